muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the ALU mult/div operations (ALUCon 4'b0011 mult, 4'b0101 div).

---
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle shift-add multiply / restoring divide for the
// ALU mult (ALUCon 4'b0011) and div (ALUCon 4'b0101) ops, writing HI/LO.
// Optional build macro: MULDIV_SIGNED_EN selects two's-complement operands
// (magnitudes are iterated, signs are applied when the result is written).
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUCon,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0]      OP_MUL = 4'b0011;
  localparam logic [3:0]      OP_DIV = 4'b0101;
  localparam int unsigned     CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // mult: {partial product high, multiplier shifting out low}
  // div:  {remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_res;                 // product / quotient must be negated
  logic neg_rem;                 // remainder must be negated (dividend negative)

  // Operand magnitudes for the unsigned iteration
  always_comb begin
    a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    b_mag = op_b[WIDTH-1] ? -op_b : op_b;
  end
`else
  // Unsigned build: operands are iterated as-is
  always_comb begin
    a_mag = op_a;
    b_mag = op_b;
  end
`endif

  // One shift-add or restoring-divide step from the current accumulator
  always_comb begin
    mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                       : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_step  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd};
    if (!div_trial[WIDTH])
      div_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    acc_step  = (state == MUL) ? mul_step : div_step;
  end

  // Final HI/LO from the last step, with sign correction in the signed build
  always_comb begin
    fin_hi = acc_step[2*WIDTH-1:WIDTH];
    fin_lo = acc_step[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (state == MUL) begin
      if (neg_res) {fin_hi, fin_lo} = -acc_step;
    end else begin
      if (neg_res) fin_lo = -acc_step[WIDTH-1:0];
      if (neg_rem) fin_hi = -acc_step[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Sequencer FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && ALUCon == OP_MUL) begin
            state    <= MUL;
            busy     <= 1'b1;
            cnt      <= '0;
            div_zero <= 1'b0;
            acc      <= {{WIDTH{1'b0}}, b_mag};
            opnd     <= a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_res  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem  <= 1'b0;
`endif
          end else if (start && ALUCon == OP_DIV) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (op_b == '0) begin
              // Divide by zero skips iteration and completes next cycle
              state    <= FIN;
              done     <= 1'b1;
              div_zero <= 1'b1;
              hi       <= op_a;
              lo       <= '1;
            end else begin
              state    <= DIV;
              div_zero <= 1'b0;
              acc      <= {{WIDTH{1'b0}}, a_mag};
              opnd     <= b_mag;
`ifdef MULDIV_SIGNED_EN
              neg_res  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              neg_rem  <= op_a[WIDTH-1];
`endif
            end
          end
        end
        MUL, DIV: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIN;
            done  <= 1'b1;
            hi    <= fin_hi;
            lo    <= fin_lo;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// multi-cycle corner sequences, and random ops against an arithmetic model.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   ALUCon;
  logic [W-1:0] op_a, op_b, hi, lo;
  logic         busy, done, div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edz;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUCon(ALUCon),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic addv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo; v.edz = edz;
    vecs.push_back(v);
  endtask

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] r;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MUL) r = sa * sb;
    else if (b == '0) r = {a, {W{1'b1}}};
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {{W{1'b0}}, a};
    else begin
      q = sa / sb;
      m = sa % sb;
      r = {m[W-1:0], q[W-1:0]};
    end
`else
    if (op == OP_MUL) r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (b == '0) r = {a, {W{1'b1}}};
    else r = {a % b, a / b};
`endif
    return r;
  endfunction

  // Issue one op, wait (bounded) for done; report result, latency, busy gaps, idle after
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdz,
                        output int lat, output int busy_gap, output logic idle_ok);
    @(negedge clk);
    start = 1'b1; ALUCon = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_gap = 0; idle_ok = 1'b0;
    rhi = 'x; rlo = 'x; rdz = 1'bx;
    for (int c = 1; c <= 100; c++) begin
      if (!busy) busy_gap++;
      if (done) begin
        lat = c; rhi = hi; rlo = lo; rdz = div_zero;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      idle_ok = !busy && !done;
    end
  endtask

  initial begin
    logic [W-1:0] rhi, rlo, a, b;
    logic [3:0]   op;
    logic [2*W-1:0] exp;
    logic rdz, idle_ok, acc_dz;
    int lat, gap, elat;

    reset = 1'b1; start = 1'b0; ALUCon = 4'b0000; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dz", div_zero, 1'b0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

`ifdef MULDIV_SIGNED_EN
    addv(OP_MUL, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0);
    addv(OP_MUL, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0);
    addv(OP_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          1'b0);
    addv(OP_DIV, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0);
    addv(OP_DIV, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  1'b0);
    addv(OP_DIV, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  1'b0);
    addv(OP_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0);
    addv(OP_DIV, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  1'b1);
    addv(OP_DIV, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1);
`else
    addv(OP_MUL, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0);
    addv(OP_MUL, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE,  1'b0);
    addv(OP_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0);
    addv(OP_MUL, 32'd0,          32'd12345,      32'd0,          32'd0,          1'b0);
    addv(OP_DIV, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0);
    addv(OP_DIV, 32'd7,          32'd100,        32'd7,          32'd0,          1'b0);
    addv(OP_DIV, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0);
    addv(OP_DIV, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, rdz, lat, gap, idle_ok);
      elat = vecs[i].edz ? 1 : W + 1;
      check($sformatf("vec%0d_latency", i), lat, elat);
      check($sformatf("vec%0d_hi", i), rhi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), rlo, vecs[i].elo);
      check($sformatf("vec%0d_dz", i), rdz, vecs[i].edz);
      check($sformatf("vec%0d_busy_gaps", i), gap, 0);
      check($sformatf("vec%0d_idle_after", i), idle_ok, 1'b1);
    end

    // div_zero is sticky across an ignored start, cleared by next accepted start
    @(negedge clk);
    start = 1'b1; ALUCon = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_op_busy", busy, 1'b0);
    check("bad_op_dz_sticky", div_zero, 1'b1);
    check("bad_op_hilo_held", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    @(negedge clk);
    start = 1'b1; ALUCon = OP_MUL; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_clears_dz", div_zero, 1'b0);
    check("accept_busy", busy, 1'b1);
    check("mid_op_hilo_held", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // starts while busy are ignored
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; ALUCon = OP_DIV; op_a = 32'd9; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1; start = 1'b0;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    check("busy_start_done_seen", lat >= 0, 1'b1);
    check("busy_start_result", {hi, lo}, 64'd15);
    check("busy_start_dz", div_zero, 1'b0);
    // start during FIN is ignored
    start = 1'b1; ALUCon = OP_MUL; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("fin_start_ignored", busy, 1'b0);
    @(posedge clk); #1;
    check("fin_start_still_idle", busy, 1'b0);

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; ALUCon = OP_MUL; op_a = 32'd7; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_stays_idle", {busy, done}, 2'b00);
    run_op(OP_MUL, 32'd7, 32'd6, rhi, rlo, rdz, lat, gap, idle_ok);
    check("after_reset_latency", lat, W + 1);
    check("after_reset_result", {rhi, rlo}, 64'd42);

    // random ops against the arithmetic model
    for (int n = 0; n < 30; n++) begin
      op = ($urandom_range(1) != 0) ? OP_MUL : OP_DIV;
      a  = $urandom;
      b  = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      if ($urandom_range(3) == 0) a = a >> $urandom_range(31);
      exp    = model(op, a, b);
      acc_dz = (op == OP_DIV) && (b == '0);
      run_op(op, a, b, rhi, rlo, rdz, lat, gap, idle_ok);
      check($sformatf("rnd%0d_op%0h_%h_%h_hilo", n, op, a, b), {rhi, rlo}, exp);
      check($sformatf("rnd%0d_dz", n), rdz, acc_dz);
      check($sformatf("rnd%0d_latency", n), lat, acc_dz ? 1 : W + 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
